// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with two combinational read ports,
// one byte-enabled write port and a sequential whole-file clear engine.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching
// read ports; left undefined, reads return stored contents only.
module regfile_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   input  logic [DATA_W/8-1:0] wt_be,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int unsigned DEPTH = 32'(1) << ADDR_W;
   localparam int unsigned NB    = DATA_W / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                clr_busy_q, clr_busy_d;
   logic                clr_done_q, clr_done_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic                wr_en_c;
   logic [DATA_W-1:0]   wr_mask_c;

   // Expand byte enables into a bit mask
   always_comb begin
      wr_mask_c = '0;
      for (int k = 0; k < int'(NB); k++) begin
         wr_mask_c[8*k +: 8] = {8{wt_be[k]}};
      end
   end

   // A write is effective only when idle, some byte is enabled and it does not target a hardwired zero entry
   always_comb begin
      wr_en_c = we && !clr_busy_q && (wt_be != '0);
      if ((ZERO_REG != 0) && (wt_addr == '0)) begin
         wr_en_c = 1'b0;
      end
   end

   // Clear FSM next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_busy_d = clr_busy_q;
      clr_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d    = CLEAR;
               idx_d      = '0;
               clr_busy_d = 1'b1;
            end
         end
         CLEAR: begin
            if (idx_q == {ADDR_W{1'b1}}) begin
               // Last entry: hold the counter at all-ones rather than wrapping
               state_d    = IDLE;
               clr_busy_d = 1'b0;
               clr_done_d = 1'b1;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Storage next-state: clear engine has priority, writes otherwise merge enabled bytes
   always_comb begin
      mem_d = mem_q;
      if (state_q == CLEAR) begin
         mem_d[idx_q] = '0;
      end else if (wr_en_c) begin
         mem_d[wt_addr] = (mem_q[wt_addr] & ~wr_mask_c) | (wt_data & wr_mask_c);
      end
   end

   // State and storage registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         clr_busy_q <= clr_busy_d;
         clr_done_q <= clr_done_d;
         mem_q      <= mem_d;
      end
   end

   // Read port A
   always_comb begin
      ra_data = mem_q[ra_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_c && (ra_addr == wt_addr)) begin
         ra_data = (mem_q[ra_addr] & ~wr_mask_c) | (wt_data & wr_mask_c);
      end
`endif
      if ((ZERO_REG != 0) && (ra_addr == '0)) begin
         ra_data = '0;
      end
   end

   // Read port B
   always_comb begin
      rb_data = mem_q[rb_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_c && (rb_addr == wt_addr)) begin
         rb_data = (mem_q[rb_addr] & ~wr_mask_c) | (wt_data & wr_mask_c);
      end
`endif
      if ((ZERO_REG != 0) && (rb_addr == '0)) begin
         rb_data = '0;
      end
   end

   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized and directed checks of regfile_param against an
// array-based reference model; a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus.
module tb_regfile_param;

   logic        clk;
   logic        rst;
   logic [4:0]  ra_addr, rb_addr, wt_addr;
   logic        we, clr_req;
   logic [31:0] wt_data;
   logic [3:0]  wt_be;
   logic [31:0] ra1, rb1, ra0, rb0;
   logic        busy1, done1, busy0, done0;

   int errors = 0;
   int checks = 0;

   // Reference model
   logic [31:0] m1 [32];
   logic [31:0] m0 [32];
   int          m_busy;
   bit          m_done;

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut1 (
      .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra1), .rb_data(rb1), .we(we), .wt_addr(wt_addr),
      .wt_data(wt_data), .wt_be(wt_be), .clr_req(clr_req),
      .clr_busy(busy1), .clr_done(done1));

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
      .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra0), .rb_data(rb0), .we(we), .wt_addr(wt_addr),
      .wt_data(wt_data), .wt_be(wt_be), .clr_req(clr_req),
      .clr_busy(busy0), .clr_done(done0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
      return r;
   endfunction

   // Expected read value for instance with zero register (z=1) or without (z=0)
   function automatic logic [31:0] exp_rd(input bit z, input logic [4:0] a);
      logic [31:0] v;
      v = z ? m1[a] : m0[a];
`ifdef REGFILE_BYPASS_EN
      if (we && m_busy == 0 && wt_be != 4'h0 && a == wt_addr && !(z && a == 5'd0))
         v = merge(v, wt_data, wt_be);
`endif
      if (z && a == 5'd0) v = 32'h0;
      return v;
   endfunction

   task automatic mreset();
      for (int i = 0; i < 32; i++) begin m1[i] = 32'h0; m0[i] = 32'h0; end
      m_busy = 0;
      m_done = 1'b0;
   endtask

   // One clock edge: model follows the rules with the inputs present at the edge
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (m_busy > 0) begin
            m1[32 - m_busy] = 32'h0;
            m0[32 - m_busy] = 32'h0;
            m_busy--;
            m_done = (m_busy == 0);
         end else begin
            m_done = 1'b0;
            if (we && wt_be != 4'h0) begin
               m0[wt_addr] = merge(m0[wt_addr], wt_data, wt_be);
               if (wt_addr != 5'd0) m1[wt_addr] = merge(m1[wt_addr], wt_data, wt_be);
            end
            if (clr_req) m_busy = 32;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; clr_req = 1'b0; wt_addr = '0; wt_data = '0; wt_be = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      ra_addr = 5'd9; rb_addr = 5'd31;
      mreset();
      #3;
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done1); end
      checks++; if (ra0 !== 32'h0) begin errors++; $display("FAIL reset_ra got %h exp 0", ra0); end
      checks++; if (rb0 !== 32'h0) begin errors++; $display("FAIL reset_rb got %h exp 0", rb0); end
      @(posedge clk); #1;
      rst = 1'b0;
      // First edge after reset release must take a write
      we = 1'b1; wt_addr = 5'd9; wt_data = 32'h0BAD_F00D; wt_be = 4'hF;
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL post_reset_write got %h exp 0badf00d", ra1); end
   endtask

   task automatic test_directed();
      we = 1'b1; wt_addr = 5'd5; wt_data = 32'hDEAD_BEEF; wt_be = 4'hF; ra_addr = 5'd5; rb_addr = 5'd5;
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_full got %h exp deadbeef", ra1); end
      we = 1'b1; wt_data = 32'h1122_3344; wt_be = 4'b0101;
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'hDE22_BE44) begin errors++; $display("FAIL write_partial got %h exp de22be44", ra1); end
      checks++; if (rb1 !== 32'hDE22_BE44) begin errors++; $display("FAIL same_addr_rb got %h exp de22be44", rb1); end
      we = 1'b1; wt_data = 32'hFFFF_FFFF; wt_be = 4'h0;
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'hDE22_BE44) begin errors++; $display("FAIL write_be0 got %h exp de22be44", ra1); end
      we = 1'b1; wt_addr = 5'd0; wt_data = 32'hFFFF_FFFF; wt_be = 4'hF; ra_addr = 5'd0; rb_addr = 5'd0;
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'h0) begin errors++; $display("FAIL zero_reg1 got %h exp 0", ra1); end
      checks++; if (ra0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_reg0 got %h exp ffffffff", ra0); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
      we = 1'b1; wt_addr = 5'd7; wt_data = 32'h1234_5678; wt_be = 4'hF;
      tick();
      ra_addr = 5'd7; rb_addr = 5'd6;
      wt_data = 32'hCAFE_F00D;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hCAFE_F00D;
`else
      exp_same = 32'h1234_5678;
`endif
      checks++; if (ra1 !== exp_same) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", ra1, exp_same); end
      tick();
      we = 1'b0; #1;
      checks++; if (ra1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL bypass_next_cycle got %h exp cafef00d", ra1); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         we      = ($urandom_range(1, 0) == 1);
         wt_addr = 5'($urandom_range(31, 0));
         wt_data = $urandom;
         wt_be   = 4'($urandom_range(15, 0));
         clr_req = ($urandom_range(59, 0) == 0);
         ra_addr = ($urandom_range(3, 0) == 0) ? wt_addr : 5'($urandom_range(31, 0));
         rb_addr = ($urandom_range(3, 0) == 0) ? ra_addr : 5'($urandom_range(31, 0));
         #1;
         checks++; if (ra1 !== exp_rd(1'b1, ra_addr)) begin errors++; $display("FAIL rnd_ra1 addr %0d got %h exp %h", ra_addr, ra1, exp_rd(1'b1, ra_addr)); end
         checks++; if (rb1 !== exp_rd(1'b1, rb_addr)) begin errors++; $display("FAIL rnd_rb1 addr %0d got %h exp %h", rb_addr, rb1, exp_rd(1'b1, rb_addr)); end
         checks++; if (ra0 !== exp_rd(1'b0, ra_addr)) begin errors++; $display("FAIL rnd_ra0 addr %0d got %h exp %h", ra_addr, ra0, exp_rd(1'b0, ra_addr)); end
         checks++; if (rb0 !== exp_rd(1'b0, rb_addr)) begin errors++; $display("FAIL rnd_rb0 addr %0d got %h exp %h", rb_addr, rb0, exp_rd(1'b0, rb_addr)); end
         checks++; if (busy1 !== (m_busy > 0)) begin errors++; $display("FAIL rnd_busy got %b exp %b", busy1, (m_busy > 0)); end
         checks++; if (done1 !== m_done || done0 !== m_done) begin errors++; $display("FAIL rnd_done got %b/%b exp %b", done1, done0, m_done); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_clear();
      int busy_cnt, done_cnt, guard;
      guard = 0;
      idle_inputs();
      while (m_busy > 0 && guard < 40) begin tick(); guard++; end
      tick();
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; wt_addr = 5'(i); wt_data = 32'(i + 1); wt_be = 4'hF;
         tick();
      end
      we = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy1) busy_cnt++;
         if (done1) done_cnt++;
         we = (k == 3); wt_addr = 5'd3; wt_data = 32'hAAAA_5555; wt_be = 4'hF;
         tick();
      end
      we = 1'b0;
      checks++; if (busy_cnt != 32) begin errors++; $display("FAIL clear_busy_cycles got %0d exp 32", busy_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL clear_done_pulses got %0d exp 1", done_cnt); end
      for (int i = 0; i < 32; i++) begin
         ra_addr = 5'(i); rb_addr = 5'(31 - i);
         #1;
         checks++; if (ra0 !== 32'h0 || rb0 !== 32'h0) begin errors++; $display("FAIL clear_zero entry %0d got %h/%h exp 0", i, ra0, rb0); end
      end
      // Held request restarts on the edge after clr_done
      clr_req = 1'b1;
      tick();
      guard = 0;
      while (!done1 && guard < 40) begin tick(); guard++; end
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL held_req_done got %b exp 1", done1); end
      tick();
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL held_req_restart got busy %b done %b exp 1 0", busy1, done1); end
      clr_req = 1'b0;
      guard = 0;
      while (m_busy > 0 && guard < 40) begin tick(); guard++; end
   endtask

   task automatic test_reset_mid_clear();
      int done_cnt;
      idle_inputs();
      we = 1'b1; wt_addr = 5'd20; wt_data = 32'h5555_AAAA; wt_be = 4'hF;
      tick();
      wt_addr = 5'd31; wt_data = 32'h7777_1111;
      tick();
      we = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      ra_addr = 5'd20; rb_addr = 5'd31;
      #1;
      checks++; if (ra0 !== 32'h5555_AAAA) begin errors++; $display("FAIL busy_read_old got %h exp 5555aaaa", ra0); end
      rst = 1'b1;
      mreset();
      #1;
      checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b/%b exp 0", busy1, busy0); end
      checks++; if (ra0 !== 32'h0 || rb0 !== 32'h0) begin errors++; $display("FAIL midclr_zero got %h/%h exp 0", ra0, rb0); end
      tick();
      rst = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (done1 || done0) done_cnt++;
         tick();
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL midclr_no_done got %0d exp 0", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_bypass();
      test_random();
      test_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving a depth of 2^ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: 1 = entry 0 hardwired to zero, 0 = entry 0 ordinary.
REQ-004 The block SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 The block SHALL have port ra_addr, input, ADDR_W, read port A address.
REQ-007 The block SHALL have port rb_addr, input, ADDR_W, read port B address.
REQ-008 The block SHALL have port ra_data, output, DATA_W, read port A data (combinational).
REQ-009 The block SHALL have port rb_data, output, DATA_W, read port B data (combinational).
REQ-010 The block SHALL have port we, input, 1, write enable.
REQ-011 The block SHALL have port wt_addr, input, ADDR_W, write address.
REQ-012 The block SHALL have port wt_data, input, DATA_W, write data.
REQ-013 The block SHALL have port wt_be, input, DATA_W/8, byte enables; bit k selects byte k.
REQ-014 The block SHALL have port clr_req, input, 1, request to clear the whole file.
REQ-015 The block SHALL have port clr_busy, output, 1, registered, high while the clear sequence runs.
REQ-016 The block SHALL have port clr_done, output, 1, registered, one-cycle pulse when the clear completes.

Function
REQ-017 Reads SHALL be combinational, zero latency, returning the stored entry; with ZERO_REG=1, address 0 SHALL read 0.
REQ-018 When we=1 and clr_busy=0, each byte k of entry wt_addr with wt_be[k]=1 SHALL take wt_data byte k at the clock edge; other bytes are unchanged.
REQ-019 When wt_be is all zeros, or when ZERO_REG=1 and wt_addr=0, a write SHALL change nothing.
REQ-020 The clear FSM SHALL have two states, IDLE and CLEAR; reset enters IDLE.
REQ-021 In IDLE with clr_req=1 at an edge, the FSM SHALL enter CLEAR, set the index counter to 0 and set clr_busy=1.
REQ-022 In CLEAR, each edge SHALL zero the entry at the index counter and increment the counter.
REQ-023 At the edge that zeros entry 2^ADDR_W-1, the FSM SHALL return to IDLE, clear clr_busy and drive clr_done=1 for exactly one cycle.
REQ-024 clr_busy SHALL be high for exactly 2^ADDR_W cycles per clear.
REQ-025 The index counter SHALL be ADDR_W bits wide and SHALL stop the sequence at all-ones, with no wrap.
REQ-026 While clr_busy=1, writes SHALL be ignored and clr_req SHALL be ignored.
REQ-027 While clr_busy=1, reads SHALL return current contents; entries not yet cleared keep old data.
REQ-028 clr_req=1 held in IDLE on the cycle after clr_done SHALL start a new clear sequence.
REQ-029 Both read ports SHALL be able to address the same entry in the same cycle and SHALL return identical data.

Reset
REQ-030 While rst=1, all entries SHALL be 0, the FSM SHALL be IDLE, the counter SHALL be 0, and clr_busy=0 and clr_done=0, independent of clk.
REQ-031 Reset asserted mid-clear SHALL abort the sequence immediately; no clr_done pulse SHALL follow.
REQ-032 The first edge after rst deasserts SHALL accept writes and clr_req normally.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined: when we=1, clr_busy=0, the read address equals wt_addr and the write is not suppressed by REQ-019, that read port SHALL output the stored value with the enabled bytes replaced by wt_data in the same cycle.
REQ-034 Without REGFILE_BYPASS_EN: read ports SHALL output only stored values, so new data appears the cycle after the write edge.

Verification
REQ-035 Reset, then write 0xDEADBEEF to r5 with be=0xF, then read ra_addr=5 on the next cycle -> ra_data=0xDEADBEEF.
REQ-036 With r5=0xDEADBEEF, write wt_data=0x11223344 with be=0b0101 -> r5=0xDE22BE44; then write with be=0 -> r5 unchanged.
REQ-037 With ZERO_REG=1, write 0xFFFFFFFF to r0 -> ra_data=0 for ra_addr=0; with ZERO_REG=0, the same write reads back 0xFFFFFFFF.
REQ-038 Fill all entries with index+1, pulse clr_req, and write r3 during busy -> clr_busy high for 32 cycles, one clr_done pulse, all entries 0, the r3 write lost.
REQ-039 Assert rst on the 10th cycle of a clear -> all entries 0 immediately, clr_busy=0, no clr_done pulse.
REQ-040 With REGFILE_BYPASS_EN, write 0xCAFEF00D to r7 with ra_addr=7 -> ra_data=0xCAFEF00D in the same cycle; without the macro, old data that cycle and new data the next.
